// File: rtl/router_pkt_src_if.sv
// Host-command, payload-stream and router-side signals of the packet source.
// The design sits on the slave modport; the host/router model drives the master side.
interface router_pkt_src_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_addr;
  logic [5:0]       cmd_len;
  logic             cmd_err;
  logic             pld_valid;
  logic [7:0]       pld_data;
  logic             pld_ready;
  logic             busy;
  logic             pkt_valid;
  logic [7:0]       data_out;
  logic             pkt_done;
  logic [CNT_W-1:0] pkt_count;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, pld_valid, pld_data, busy,
    input  cmd_ready, cmd_err, pld_ready, pkt_valid, data_out, pkt_done, pkt_count
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, pld_valid, pld_data, busy,
    output cmd_ready, cmd_err, pld_ready, pkt_valid, data_out, pkt_done, pkt_count
  );
endinterface

// File: rtl/router_pkt_src.sv
// Buffers a host payload, then emits one router packet: header, payload, parity.
// Beats advance only while the router is not busy; completion is pulsed and counted.
module router_pkt_src #(
  parameter int MAX_LEN = 63,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  router_pkt_src_if.slave  bus
);
  localparam int PTR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  function automatic logic [7:0] hdr_byte(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

  function automatic logic [7:0] parity_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  state_t             state_r, state_s;
  logic [1:0]         addr_r, addr_s;
  logic [5:0]         len_r, len_s;
  logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_s;
  logic [PTR_W-1:0]   rd_ptr_r, rd_ptr_s;
  logic [7:0]         parity_r, parity_s;
  logic               cmd_err_r, cmd_err_s;
  logic               pkt_valid_r, pkt_valid_s;
  logic [7:0]         data_out_r, data_out_s;
  logic               pkt_done_r, pkt_done_s;
  logic [CNT_W-1:0]   pkt_count_r, pkt_count_s;
  logic               mem_we_s;
  logic               cmd_fire_s, pld_fire_s, accept_s;
  logic [7:0]         pld_mem_r [0:MAX_LEN];

  assign bus.cmd_ready = (state_r == ST_IDLE);
  assign bus.pld_ready = (state_r == ST_LOAD);
  assign bus.cmd_err   = cmd_err_r;
  assign bus.pkt_valid = pkt_valid_r;
  assign bus.data_out  = data_out_r;
  assign bus.pkt_done  = pkt_done_r;
  assign bus.pkt_count = pkt_count_r;

  assign cmd_fire_s = bus.cmd_valid && (state_r == ST_IDLE);
  assign pld_fire_s = bus.pld_valid && (state_r == ST_LOAD);
  assign accept_s   = !bus.busy;

  // Next-state and next registered-output decode.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    len_s       = len_r;
    wr_ptr_s    = wr_ptr_r;
    rd_ptr_s    = rd_ptr_r;
    parity_s    = parity_r;
    cmd_err_s   = 1'b0;
    pkt_valid_s = pkt_valid_r;
    data_out_s  = data_out_r;
    pkt_done_s  = 1'b0;
    pkt_count_s = pkt_count_r;
    mem_we_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pkt_valid_s = 1'b0;
        if (cmd_fire_s) begin
          if ((bus.cmd_addr == 2'd3) || (bus.cmd_len == 6'd0)) begin
            cmd_err_s = 1'b1;
          end else begin
            addr_s   = bus.cmd_addr;
            len_s    = bus.cmd_len;
            parity_s = hdr_byte(bus.cmd_len, bus.cmd_addr);
            wr_ptr_s = {PTR_W{1'b0}};
            state_s  = ST_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (pld_fire_s) begin
          mem_we_s = 1'b1;
          wr_ptr_s = wr_ptr_r + 6'd1;
          parity_s = parity_fold(parity_r, bus.pld_data);
          if (wr_ptr_r == (len_r - 6'd1)) begin
            pkt_valid_s = 1'b1;
            data_out_s  = hdr_byte(len_r, addr_r);
            state_s     = ST_HEADER;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_HEADER: begin
        if (accept_s) begin
          data_out_s = pld_mem_r[6'd0];
          rd_ptr_s   = 6'd1;
          state_s    = ST_PAYLOAD;
        end else begin
          state_s = ST_HEADER;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s) begin
          // rd_ptr counts bytes already presented, so equality means the last one just left.
          if (rd_ptr_r == len_r) begin
            pkt_valid_s = 1'b0;
            data_out_s  = parity_r;
            state_s     = ST_PARITY;
          end else begin
            data_out_s = pld_mem_r[rd_ptr_r];
            rd_ptr_s   = rd_ptr_r + 6'd1;
          end
        end else begin
          state_s = ST_PAYLOAD;
        end
      end
      ST_PARITY: begin
        if (accept_s) begin
          data_out_s  = 8'h00;
          pkt_done_s  = 1'b1;
          pkt_count_s = pkt_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          state_s     = ST_GAP;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_GAP: begin
        state_s = ST_IDLE;
      end
      default: begin
        pkt_valid_s = 1'b0;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_r     <= ST_IDLE;
      addr_r      <= 2'd0;
      len_r       <= 6'd0;
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      parity_r    <= 8'h00;
      cmd_err_r   <= 1'b0;
      pkt_valid_r <= 1'b0;
      data_out_r  <= 8'h00;
      pkt_done_r  <= 1'b0;
      pkt_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      len_r       <= len_s;
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      parity_r    <= parity_s;
      cmd_err_r   <= cmd_err_s;
      pkt_valid_r <= pkt_valid_s;
      data_out_r  <= data_out_s;
      pkt_done_r  <= pkt_done_s;
      pkt_count_r <= pkt_count_s;
    end
  end

  // Payload buffer write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      pld_mem_r[wr_ptr_r] <= bus.pld_data;
    end
  end
endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src: hand-computed headers, payload order, parity,
// back-pressure, rejected commands, inter-packet gap and reset abandonment.
module tb_router_pkt_src;
  logic clk;
  logic resetn;
  int   checks_cnt;
  int   fail_cnt;
  logic [7:0] pay [0:63];
  int   low_cnt;

  router_pkt_src_if #(.CNT_W(16)) bus ();

  router_pkt_src #(.MAX_LEN(63), .CNT_W(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_packet(input logic [1:0] a, input int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = len[5:0];
    check_val("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      bus.pld_valid = 1'b1;
      bus.pld_data  = pay[i];
      step();
    end
    bus.pld_valid = 1'b0;
  endtask

  task automatic emit_packet(input logic [7:0] hdr, input int len, input logic [7:0] par,
                             input logic [15:0] cnt, input int stall_idx, input int stall_n,
                             input bit par_stall);
    check_val("hdr_data", 32'(bus.data_out), 32'(hdr));
    check_val("hdr_valid", 32'(bus.pkt_valid), 32'd1);
    check_val("hdr_pld_ready", 32'(bus.pld_ready), 32'd0);
    step();
    for (int i = 0; i < len; i++) begin
      if (i == stall_idx) begin
        for (int s = 0; s < stall_n; s++) begin
          check_val("stall_data", 32'(bus.data_out), 32'(pay[i]));
          check_val("stall_valid", 32'(bus.pkt_valid), 32'd1);
          bus.busy = 1'b1;
          step();
        end
        bus.busy = 1'b0;
      end
      check_val("pld_data", 32'(bus.data_out), 32'(pay[i]));
      check_val("pld_valid", 32'(bus.pkt_valid), 32'd1);
      step();
    end
    if (par_stall) begin
      bus.busy = 1'b1;
      step();
      bus.busy = 1'b0;
    end
    check_val("par_data", 32'(bus.data_out), 32'(par));
    check_val("par_valid", 32'(bus.pkt_valid), 32'd0);
    check_val("par_no_done", 32'(bus.pkt_done), 32'd0);
    step();
    check_val("done_pulse", 32'(bus.pkt_done), 32'd1);
    check_val("done_data", 32'(bus.data_out), 32'd0);
    check_val("done_count", 32'(bus.pkt_count), 32'(cnt));
    check_val("gap_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    step();
    check_val("done_clear", 32'(bus.pkt_done), 32'd0);
  endtask

  task automatic bad_cmd(input logic [1:0] a, input logic [5:0] len, input logic [15:0] cnt);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    step();
    bus.cmd_valid = 1'b0;
    check_val("err_pulse", 32'(bus.cmd_err), 32'd1);
    check_val("err_pld_ready", 32'(bus.pld_ready), 32'd0);
    check_val("err_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    check_val("err_clear", 32'(bus.cmd_err), 32'd0);
    check_val("err_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    check_val("err_pld_ready2", 32'(bus.pld_ready), 32'd0);
    check_val("err_count", 32'(bus.pkt_count), 32'(cnt));
  endtask

  initial begin
    checks_cnt    = 0;
    fail_cnt      = 0;
    resetn        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 2'd0;
    bus.cmd_len   = 6'd0;
    bus.pld_valid = 1'b0;
    bus.pld_data  = 8'h00;
    bus.busy      = 1'b0;
    step();
    step();
    resetn = 1'b0;
    check_val("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    check_val("rst_data_out", 32'(bus.data_out), 32'd0);
    check_val("rst_pkt_done", 32'(bus.pkt_done), 32'd0);
    check_val("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    check_val("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
    check_val("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_val("rst_pld_ready", 32'(bus.pld_ready), 32'd0);

    // Basic send: header {3,1}=0x0D, parity 0x0D^0x11^0x22^0x33 = 0x0D.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    load_packet(2'd1, 3);
    emit_packet(8'h0D, 3, 8'h0D, 16'd1, -1, 0, 1'b0);

    // Back-pressure on 0x22 for three cycles.
    load_packet(2'd1, 3);
    emit_packet(8'h0D, 3, 8'h0D, 16'd2, 1, 3, 1'b0);

    // Rejected commands.
    bad_cmd(2'd3, 6'd5, 16'd2);
    bad_cmd(2'd0, 6'd0, 16'd2);

    // Max length: header {63,2}=0xFE, parity 0xFE ^ 0x3F = 0xC1; parity beat stalled once.
    for (int i = 0; i < 63; i++) pay[i] = 8'(i);
    load_packet(2'd2, 63);
    emit_packet(8'hFE, 63, 8'hC1, 16'd3, 0, 1, 1'b1);

    // Back-to-back: A = addr0 len1 0xA5 (hdr 0x04, par 0xA1); B = addr2 len1 0x5A (hdr 0x06, par 0x5C).
    pay[0] = 8'hA5;
    load_packet(2'd0, 1);
    check_val("b2b_hdr_a", 32'(bus.data_out), 32'h04);
    step();
    check_val("b2b_pld_a", 32'(bus.data_out), 32'hA5);
    step();
    check_val("b2b_par_a", 32'(bus.data_out), 32'hA1);
    low_cnt       = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 2'd2;
    bus.cmd_len   = 6'd1;
    for (int c = 0; c < 4; c++) begin
      if (bus.pkt_valid == 1'b0) low_cnt++;
      if (c == 1) check_val("b2b_gap_ready", 32'(bus.cmd_ready), 32'd0);
      if (c == 2) begin
        check_val("b2b_idle_ready", 32'(bus.cmd_ready), 32'd1);
      end
      if (c == 3) begin
        bus.pld_valid = 1'b1;
        bus.pld_data  = 8'h5A;
      end
      step();
      if (c == 2) bus.cmd_valid = 1'b0;
    end
    bus.pld_valid = 1'b0;
    check_val("b2b_low_cycles", 32'(low_cnt), 32'd4);
    pay[0] = 8'h5A;
    emit_packet(8'h06, 1, 8'h5C, 16'd5, -1, 0, 1'b0);

    // Reset while loading the payload.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 2'd1;
    bus.cmd_len   = 6'd3;
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.pld_valid = 1'b1;
      bus.pld_data  = pay[i];
      step();
    end
    bus.pld_valid = 1'b0;
    resetn = 1'b1;
    step();
    resetn = 1'b0;
    check_val("rstl_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    check_val("rstl_data_out", 32'(bus.data_out), 32'd0);
    check_val("rstl_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_val("rstl_pkt_count", 32'(bus.pkt_count), 32'd0);
    load_packet(2'd1, 3);
    emit_packet(8'h0D, 3, 8'h0D, 16'd1, -1, 0, 1'b0);

    // Reset while emitting: packet abandoned, no parity follows.
    load_packet(2'd1, 3);
    step();
    step();
    check_val("rste_pre_data", 32'(bus.data_out), 32'h22);
    resetn = 1'b1;
    step();
    resetn = 1'b0;
    check_val("rste_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    check_val("rste_data_out", 32'(bus.data_out), 32'd0);
    check_val("rste_pkt_count", 32'(bus.pkt_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rste_quiet_valid", 32'(bus.pkt_valid), 32'd0);
      check_val("rste_quiet_data", 32'(bus.data_out), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end
endmodule
